// File: rtl/equiv_pkg.sv
// Shared types and constants for the lockstep equivalence checker.
package equiv_pkg;

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_CHECK  = 2'd1,
        S_HALT   = 2'd2
    } state_e;

    localparam int DLY_MAX = 15;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/equiv_delay_line.sv
// En-qualified alignment delay for the golden bus; a plain wire when DLY=0.
module equiv_delay_line #(
    parameter int WIDTH = 91,
    parameter int DLY   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DLY == 0) begin : g_wire
            logic unused_dly;
            assign unused_dly = ^{clk, rst_n, en_i};
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_q [DLY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DLY; i++) pipe_q[i] <= '0;
                end else if (en_i) begin
                    pipe_q[0] <= d_i;
                    for (int i = 1; i < DLY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign q_o = pipe_q[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/equiv_lockstep_checker.sv
// Golden-vs-NCH lockstep compare with warm-up mask, saturating counters, first-fail capture.
// Define EQUIV_ASSERT_EN to add per-channel immediate assertions in CHECK.
module equiv_lockstep_checker
    import equiv_pkg::*;
#(
    parameter int WIDTH        = 91,
    parameter int NCH          = 2,
    parameter int DLY          = 0,
    parameter int WARMUP       = 4,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       y_ref,
    input  logic [NCH*WIDTH-1:0]   y_dut,
    output logic [NCH-1:0]         mismatch,
    output logic                   fail,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [CNT_W-1:0]       cyc_cnt,
    output logic [ch_w(NCH)-1:0]   first_ch,
    output logic [CNT_W-1:0]       first_cyc,
    output logic [WIDTH-1:0]       first_diff,
    output logic                   checking
);

    localparam int DLY_E  = (DLY > DLY_MAX) ? DLY_MAX : DLY;
    localparam int WU_TOT = WARMUP + DLY_E;
    localparam int WU_W   = (WU_TOT > 1) ? $clog2(WU_TOT) : 1;
    localparam int CH_W   = ch_w(NCH);
    localparam logic [WU_W-1:0] WU_LAST = WU_W'((WU_TOT > 0) ? WU_TOT - 1 : 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic [WU_W-1:0]   wu_q, wu_d;
    logic [NCH-1:0]    mm_q, mm_d;
    logic              fail_q, fail_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  ccnt_q, ccnt_d;
    logic [CH_W-1:0]   fch_q, fch_d;
    logic [CNT_W-1:0]  fcyc_q, fcyc_d;
    logic [WIDTH-1:0]  fdiff_q, fdiff_d;

    logic [WIDTH-1:0]  ref_al;
    logic [NCH-1:0]    cmp;
    logic [CH_W-1:0]   lo_ch;
    logic [WIDTH-1:0]  lo_diff;

    equiv_delay_line #(
        .WIDTH (WIDTH),
        .DLY   (DLY_E)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .d_i   (y_ref),
        .q_o   (ref_al)
    );

    // Descending scan so the lowest mismatching channel is the last one written.
    always_comb begin
        cmp     = '0;
        lo_ch   = '0;
        lo_diff = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cmp[k] = (y_dut[k*WIDTH +: WIDTH] !== ref_al);
            if (cmp[k]) begin
                lo_ch   = CH_W'(k);
                lo_diff = ref_al ^ y_dut[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wu_d    = wu_q;
        mm_d    = mm_q;
        fail_d  = fail_q;
        fcnt_d  = fcnt_q;
        ccnt_d  = ccnt_q;
        fch_d   = fch_q;
        fcyc_d  = fcyc_q;
        fdiff_d = fdiff_q;
        if (clear) begin
            state_d = S_WARMUP;
            wu_d    = '0;
            mm_d    = '0;
            fail_d  = 1'b0;
            fcnt_d  = '0;
            ccnt_d  = '0;
            fch_d   = '0;
            fcyc_d  = '0;
            fdiff_d = '0;
        end else begin
            unique case (state_q)
                S_WARMUP: begin
                    mm_d = '0;
                    if (WU_TOT == 0) begin
                        state_d = S_CHECK;
                    end else if (en) begin
                        if (wu_q == WU_LAST) begin
                            state_d = S_CHECK;
                            wu_d    = '0;
                        end else begin
                            wu_d = wu_q + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    mm_d = en ? cmp : '0;
                    if (en) begin
                        ccnt_d = sat_inc(ccnt_q);
                        if (|cmp) begin
                            fail_d = 1'b1;
                            fcnt_d = sat_inc(fcnt_q);
                            if (!fail_q) begin
                                fch_d   = lo_ch;
                                fcyc_d  = ccnt_q;
                                fdiff_d = lo_diff;
                                if (STOP_ON_FAIL != 0) state_d = S_HALT;
                            end
                        end
                    end
                end
                S_HALT: begin
                end
                default: begin
                    state_d = S_WARMUP;
                    wu_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WARMUP;
            wu_q    <= '0;
            mm_q    <= '0;
            fail_q  <= 1'b0;
            fcnt_q  <= '0;
            ccnt_q  <= '0;
            fch_q   <= '0;
            fcyc_q  <= '0;
            fdiff_q <= '0;
        end else begin
            state_q <= state_d;
            wu_q    <= wu_d;
            mm_q    <= mm_d;
            fail_q  <= fail_d;
            fcnt_q  <= fcnt_d;
            ccnt_q  <= ccnt_d;
            fch_q   <= fch_d;
            fcyc_q  <= fcyc_d;
            fdiff_q <= fdiff_d;
        end
    end

`ifdef EQUIV_ASSERT_EN
    always_ff @(posedge clk) begin
        if (state_q == S_CHECK && en) begin
            for (int k = 0; k < NCH; k++) begin
                assert (y_dut[k*WIDTH +: WIDTH] == ref_al);
            end
        end
    end
`endif

    assign mismatch   = mm_q;
    assign fail       = fail_q;
    assign fail_cnt   = fcnt_q;
    assign cyc_cnt    = ccnt_q;
    assign first_ch   = fch_q;
    assign first_cyc  = fcyc_q;
    assign first_diff = fdiff_q;
    assign checking   = (state_q == S_CHECK);

endmodule

// File: tb/tb_equiv_lockstep_checker.sv
// Randomised scoreboard bench: two checker configurations against a queue-based reference model.
module tb_equiv_lockstep_checker;

    localparam int W = 91;
    localparam int N = 3;

    typedef struct packed {
        logic [N-1:0]  mm;
        logic          fail;
        logic [15:0]   fcnt;
        logic [15:0]   ccnt;
        logic [1:0]    fch;
        logic [15:0]   fcyc;
        logic [W-1:0]  fdiff;
        logic          chk;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n, en, clear;
    logic [W-1:0]   y_ref;
    logic [N*W-1:0] y_dut_a, y_dut_b;

    logic [N-1:0]   mismatch_a, mismatch_b;
    logic           fail_a, fail_b, checking_a, checking_b;
    logic [4:0]     fail_cnt_a, cyc_cnt_a, first_cyc_a;
    logic [3:0]     fail_cnt_b, cyc_cnt_b, first_cyc_b;
    logic [1:0]     first_ch_a, first_ch_b;
    logic [W-1:0]   first_diff_a, first_diff_b;

    always #5 clk = ~clk;

    equiv_lockstep_checker #(
        .WIDTH(W), .NCH(N), .DLY(0), .WARMUP(4), .CNT_W(5), .STOP_ON_FAIL(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .y_ref(y_ref), .y_dut(y_dut_a),
        .mismatch(mismatch_a), .fail(fail_a), .fail_cnt(fail_cnt_a),
        .cyc_cnt(cyc_cnt_a), .first_ch(first_ch_a), .first_cyc(first_cyc_a),
        .first_diff(first_diff_a), .checking(checking_a)
    );

    equiv_lockstep_checker #(
        .WIDTH(W), .NCH(N), .DLY(2), .WARMUP(3), .CNT_W(4), .STOP_ON_FAIL(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .y_ref(y_ref), .y_dut(y_dut_b),
        .mismatch(mismatch_b), .fail(fail_b), .fail_cnt(fail_cnt_b),
        .cyc_cnt(cyc_cnt_b), .first_ch(first_ch_b), .first_cyc(first_cyc_b),
        .first_diff(first_diff_b), .checking(checking_b)
    );

    // Reference model: phase 0=warm-up, 1=check, 2=halted
    int           m_ph[2], m_wc[2], m_fc[2], m_cc[2], m_fch[2], m_fcyc[2];
    bit           m_fail[2];
    logic [W-1:0] m_fd[2];
    logic [N-1:0] m_mm[2];
    logic [W-1:0] h0[$], h1[$];

    exp_t qa[$], qb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   fault_a, skew_b;

    function automatic int p_dly(input int id); return id ? 2 : 0; endfunction
    function automatic int p_wu(input int id);  return id ? 3 + 2 : 4; endfunction
    function automatic int p_max(input int id); return id ? 15 : 31; endfunction

    function automatic logic [W-1:0] front(input int id);
        if (p_dly(id) == 0) return y_ref;
        return id ? h1[0] : h0[0];
    endfunction

    task automatic model_reset(input int id);
        m_ph[id] = 0; m_wc[id] = 0; m_fc[id] = 0; m_cc[id] = 0;
        m_fch[id] = 0; m_fcyc[id] = 0; m_fail[id] = 0;
        m_fd[id] = '0; m_mm[id] = '0;
        if (id == 0) begin
            h0.delete();
            for (int i = 0; i < p_dly(0); i++) h0.push_back('0);
        end else begin
            h1.delete();
            for (int i = 0; i < p_dly(1); i++) h1.push_back('0);
        end
    endtask

    task automatic model_step(input int id, input logic [N*W-1:0] yd);
        logic [W-1:0] al;
        logic [N-1:0] mm;
        int lo;
        if (!rst_n) begin
            model_reset(id);
            return;
        end
        al = front(id);
        if (clear) begin
            m_ph[id] = 0; m_wc[id] = 0; m_fc[id] = 0; m_cc[id] = 0;
            m_fch[id] = 0; m_fcyc[id] = 0; m_fail[id] = 0;
            m_fd[id] = '0; m_mm[id] = '0;
        end else if (m_ph[id] == 0) begin
            m_mm[id] = '0;
            if (en) begin
                m_wc[id]++;
                if (m_wc[id] == p_wu(id)) begin
                    m_ph[id] = 1;
                    m_wc[id] = 0;
                end
            end
        end else if (m_ph[id] == 1) begin
            if (!en) begin
                m_mm[id] = '0;
            end else begin
                lo = -1;
                for (int k = N - 1; k >= 0; k--) begin
                    mm[k] = (yd[k*W +: W] !== al);
                    if (mm[k]) lo = k;
                end
                if (lo >= 0) begin
                    if (!m_fail[id]) begin
                        m_fch[id]  = lo;
                        m_fcyc[id] = m_cc[id];
                        m_fd[id]   = al ^ yd[lo*W +: W];
                        if (id == 1) m_ph[id] = 2;
                    end
                    m_fail[id] = 1;
                    if (m_fc[id] < p_max(id)) m_fc[id]++;
                end
                if (m_cc[id] < p_max(id)) m_cc[id]++;
                m_mm[id] = mm;
            end
        end
        if (en && p_dly(id) > 0) begin
            if (id == 0) begin
                h0.push_back(y_ref); void'(h0.pop_front());
            end else begin
                h1.push_back(y_ref); void'(h1.pop_front());
            end
        end
    endtask

    function automatic exp_t mk_exp(input int id);
        exp_t e;
        e.mm    = m_mm[id];
        e.fail  = m_fail[id];
        e.fcnt  = 16'(m_fc[id]);
        e.ccnt  = 16'(m_cc[id]);
        e.fch   = 2'(m_fch[id]);
        e.fcyc  = 16'(m_fcyc[id]);
        e.fdiff = m_fd[id];
        e.chk   = (m_ph[id] == 1);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic logic [N*W-1:0] mk_dut(input int id, input int err_pct);
        logic [N*W-1:0] r;
        logic [W-1:0] good, v;
        good = (id == 1 && skew_b) ? h1[1] : front(id);
        for (int k = 0; k < N; k++) begin
            v = good;
            if (int'($urandom_range(99)) < err_pct) v[$urandom_range(W-1)] ^= 1'b1;
            r[k*W +: W] = v;
        end
        return r;
    endfunction

    task automatic cyc(input int n, input int en_pct, input int err_pct, input int clr_pct);
        for (int i = 0; i < n; i++) begin
            y_ref = rnd_w();
            en    = (int'($urandom_range(99)) < en_pct);
            clear = (int'($urandom_range(99)) < clr_pct);
            y_dut_a = mk_dut(0, err_pct);
            y_dut_b = mk_dut(1, err_pct);
            if (fault_a && m_ph[0] == 1 && m_cc[0] == 5 && !m_fail[0])
                y_dut_a[W+7] ^= 1'b1;
            @(posedge clk);
            model_step(0, y_dut_a);
            model_step(1, y_dut_b);
            qa.push_back(mk_exp(0));
            qb.push_back(mk_exp(1));
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_rec(input string p, input exp_t a, input exp_t e);
        chk({p, ".mismatch"},   128'(a.mm),    128'(e.mm));
        chk({p, ".fail"},       128'(a.fail),  128'(e.fail));
        chk({p, ".fail_cnt"},   128'(a.fcnt),  128'(e.fcnt));
        chk({p, ".cyc_cnt"},    128'(a.ccnt),  128'(e.ccnt));
        chk({p, ".first_ch"},   128'(a.fch),   128'(e.fch));
        chk({p, ".first_cyc"},  128'(a.fcyc),  128'(e.fcyc));
        chk({p, ".first_diff"}, 128'(a.fdiff), 128'(e.fdiff));
        chk({p, ".checking"},   128'(a.chk),   128'(e.chk));
    endtask

    exp_t ea, eb, ra, rb;

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            ra.mm = mismatch_a; ra.fail = fail_a;
            ra.fcnt = 16'(fail_cnt_a); ra.ccnt = 16'(cyc_cnt_a);
            ra.fch = first_ch_a; ra.fcyc = 16'(first_cyc_a);
            ra.fdiff = first_diff_a; ra.chk = checking_a;
            cmp_rec("A", ra, ea);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            rb.mm = mismatch_b; rb.fail = fail_b;
            rb.fcnt = 16'(fail_cnt_b); rb.ccnt = 16'(cyc_cnt_b);
            rb.fch = first_ch_b; rb.fcyc = 16'(first_cyc_b);
            rb.fdiff = first_diff_b; rb.chk = checking_b;
            cmp_rec("B", rb, eb);
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clear = 1'b0;
        y_ref = '0; y_dut_a = '0; y_dut_b = '0;
        fault_a = 1'b0; skew_b = 1'b0;
        model_reset(0);
        model_reset(1);
        cyc(2, 0, 0, 0);
        rst_n = 1'b1;
        fault_a = 1'b1;
        cyc(25, 100, 0, 0);
        fault_a = 1'b0;
        cyc(1, 100, 0, 100);
        cyc(30, 100, 0, 0);
        cyc(60, 70, 8, 0);
        cyc(40, 100, 100, 0);
        cyc(20, 50, 100, 0);
        cyc(1, 100, 0, 100);
        skew_b = 1'b1;
        cyc(12, 100, 0, 0);
        skew_b = 1'b0;
        cyc(1, 100, 0, 100);
        cyc(15, 100, 30, 0);
        // Asynchronous reset between edges while both instances are checking
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        qa[qa.size()-1] = mk_exp(0);
        qb[qb.size()-1] = mk_exp(1);
        cyc(2, 100, 0, 0);
        rst_n = 1'b1;
        cyc(12, 100, 0, 0);
        cyc(80, 70, 8, 3);
        @(negedge clk);
        #1;
        n_chk++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", qa.size() + qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/equiv_lockstep_checker.md
Name: equiv_lockstep_checker

Overview:
- Parametrised successor to the two-copy equivalence harness: compares one golden output bus against NCH candidate implementations every clock.
- Adds alignment delay for the golden path, a warm-up mask, and saturating mismatch/cycle counters.
- Captures the first mismatch for debug; optionally halts on the first failure.
- Sits in each fuzz-equivalence top, between the instantiated design copies and the formal/simulation checker.

Parameters:
- WIDTH, 91, bit width of each compared output bus
- NCH, 2, number of candidate channels compared against the golden bus (>=1)
- DLY, 0, pipeline stages applied to y_ref before comparison (0..15)
- WARMUP, 4, enabled cycles after reset exit during which compares are masked (0 = none)
- CNT_W, 16, width of fail and cycle counters
- STOP_ON_FAIL, 0, 1 = freeze all comparison state after the first mismatch

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  sample qualifier; compare only on cycles with en=1
- clear  input  1  synchronous clear of counters, sticky flag and capture; returns FSM to WARMUP
- y_ref  input  WIDTH  golden output
- y_dut  input  NCH*WIDTH  candidate outputs; channel k at bits [k*WIDTH +: WIDTH]
- mismatch  output  NCH  per-channel compare result of the previous qualified cycle (registered)
- fail  output  1  sticky; set by the first counted mismatch
- fail_cnt  output  CNT_W  count of qualified cycles with any channel mismatching; saturates
- cyc_cnt  output  CNT_W  count of qualified compares performed in CHECK; saturates
- first_ch  output  max(1,$clog2(NCH))  lowest-index mismatching channel of the first failure
- first_cyc  output  CNT_W  cyc_cnt value at the first failure
- first_diff  output  WIDTH  y_ref XOR y_dut[first_ch] at the first failure
- checking  output  1  high while the FSM is in CHECK

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs clear to 0.
  - Delay line clears to 0.
  - FSM enters WARMUP with the warm-up counter at 0.
- Delay line:
  - y_ref passes through DLY registers that advance only when en=1.
  - DLY=0 means y_ref is used directly.
  - The delay line is never cleared by `clear`.
- FSM states are WARMUP, CHECK and HALT.
- WARMUP:
  - Each en=1 cycle increments the warm-up counter.
  - The FSM moves to CHECK after WARMUP+DLY enabled cycles, so delay-line fill is also masked.
  - If WARMUP+DLY=0, the FSM enters CHECK on the first clock after reset.
  - mismatch is held at 0 in this state.
- CHECK, on each en=1 cycle:
  - mismatch[k] <= (ref_aligned != y_dut[k]) for every k.
  - cyc_cnt increments.
  - If any channel mismatches, fail_cnt increments and fail is set.
  - If fail was 0, first_ch, first_cyc (pre-increment cyc_cnt) and first_diff are captured. The lowest index wins on simultaneous channel mismatches.
  - With STOP_ON_FAIL=1, the FSM goes to HALT on the cycle the first failure is recorded.
- en=0 in CHECK: mismatch clears to 0 and all counters hold.
- HALT:
  - mismatch, counters and capture are frozen.
  - The FSM leaves HALT only via clear or reset.
- Latency: a mismatch on the inputs at edge N appears on mismatch/fail at edge N+1 (after DLY alignment).
- Saturation: counters stick at 2^CNT_W-1, which also stops cyc_cnt from wrapping.
- clear:
  - clear=1 zeroes the counters, fail, capture and mismatch, and moves the FSM to WARMUP.
  - clear has priority over a mismatch in the same cycle.
- Equality is exact bitwise; X/Z on an input counts as a mismatch in simulation (!== semantics).

Optional Feature:
- Macro: EQUIV_ASSERT_EN.
- Defined: an immediate assertion (y_dut[k] == ref_aligned) fires in CHECK on en=1 for each channel, for formal/simulation use.
- Undefined: no assertion code is emitted; the block is purely synthesizable monitoring logic.

Decomposition:
- Package equiv_pkg holds:
  - the FSM state enum (WARMUP/CHECK/HALT)
  - the DLY_MAX=15 constant
  - the channel-index width function
- One sub-module, equiv_delay_line, implements the parameterised en-qualified delay (WIDTH, DLY). It degenerates to a wire for DLY=0.

Test Plan:
- Equal streams: NCH=2, DLY=0, WARMUP=4, 20 en cycles with identical y_ref/y_dut → fail=0, fail_cnt=0, cyc_cnt=16.
- Injected fault: flip bit 7 of channel 1 at compare cycle 5 → fail=1, fail_cnt=1, first_ch=1, first_cyc=5, first_diff=0x80.
- Skew: DLY=2, dut lags ref by 2 cycles with equal data → no mismatch; DLY=1 with the same stimulus → mismatch on every cycle after warm-up.
- STOP_ON_FAIL=1: mismatches on both channels at cycle 3 → first_ch=0, FSM HALT; later mismatches leave fail_cnt=1. Asserting clear → counters 0, checking=0 until warm-up completes.
- Saturation and en gating: CNT_W=4, constant mismatch for 30 cycles → fail_cnt=15; en=0 bubbles leave the counters unchanged.
- Async reset mid-CHECK: drop rst_n between edges → all outputs 0 immediately; after release, 4 masked cycles before checking=1.
